acc_send: RTL and testbench

Transmit-side MPI accelerator for eager messages, driven by the NIOS II custom-instruction interface. On a SEND request it reads the user buffer word by word from main memory through an Avalon-MM read master. Each word becomes one 128-bit eager packet toward the router, in the same layout the receive engine matches on. When the whole message is accepted, or a timeout expires, it returns a completion code to the CPU.

---
 rtl/acc_send_pkg.sv | 39 +++
 rtl/acc_send_pkt_build.sv | 24 ++
 rtl/acc_send.sv | 175 +++++++++++++++++
 tb/tb_acc_send.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_send_pkg.sv
// Shared constants and types for the eager-message accelerators.
// Also used by acc_recv, so the packet layout is defined only here.
package acc_send_pkg;

    localparam int unsigned PKT_W  = 128;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 11;

    localparam logic [2:0] OP_SETLEN = 3'b001;
    localparam logic [2:0] OP_SEND   = 3'b010;

    localparam logic [4:0] PKT_TYPE_EAGER = 5'b10000;

    // Eager packet field positions
    localparam int unsigned PKT_TYPE_HI  = 127;
    localparam int unsigned PKT_TYPE_LO  = 123;
    localparam int unsigned PKT_DEST_HI  = 119;
    localparam int unsigned PKT_DEST_LO  = 112;
    localparam int unsigned PKT_RANK_HI  = 111;
    localparam int unsigned PKT_RANK_LO  = 104;
    localparam int unsigned PKT_MATCH_HI = 103;
    localparam int unsigned PKT_MATCH_LO = 88;
    localparam int unsigned PKT_DATA_HI  = 87;
    localparam int unsigned PKT_DATA_LO  = 56;
    localparam int unsigned PKT_IDX_HI   = 10;
    localparam int unsigned PKT_IDX_LO   = 0;

    localparam logic [31:0] RES_TIMEOUT = 32'hdeaddead;
    localparam logic [31:0] RES_ILLEGAL = 32'hbadc0de0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND,
        ST_FIN
    } send_state_e;

endpackage

// File: rtl/acc_send_pkt_build.sv
// Combinational eager-packet assembler (dest, rank, match, data, idx -> 128 bits).
// Kept separate so an RNDV/CTS sender can reuse the same layout.
module acc_send_pkt_build
    import acc_send_pkg::*;
(
    input  logic [7:0]        i_dest,
    input  logic [7:0]        i_rank,
    input  logic [15:0]       i_match,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [PKT_W-1:0]  o_packet_c
);

    always_comb begin
        o_packet_c = '0;
        o_packet_c[PKT_TYPE_HI:PKT_TYPE_LO]   = PKT_TYPE_EAGER;
        o_packet_c[PKT_DEST_HI:PKT_DEST_LO]   = i_dest;
        o_packet_c[PKT_RANK_HI:PKT_RANK_LO]   = i_rank;
        o_packet_c[PKT_MATCH_HI:PKT_MATCH_LO] = i_match;
        o_packet_c[PKT_DATA_HI:PKT_DATA_LO]   = i_data;
        o_packet_c[PKT_IDX_HI:PKT_IDX_LO]     = i_idx;
    end

endmodule

// File: rtl/acc_send.sv
// Eager-message transmit engine: reads a user buffer over Avalon-MM and emits
// one packet per word to the router, then reports a completion code to the CPU.
module acc_send
    import acc_send_pkg::*;
#(
    parameter int unsigned packetizer_width = 128,
    parameter int unsigned data_width       = 32,
    parameter logic [7:0]  MY_RANK          = 8'd0,
    parameter int unsigned TIMEOUT          = 100000000
) (
    input  logic                        nios_clk,
    input  logic                        reset,
    input  logic [31:0]                 data_in_a,
    input  logic [31:0]                 data_in_b,
    input  logic [2:0]                  in_opcode,
    input  logic                        start,
    output logic [31:0]                 result,
    output logic                        done,
    output logic                        read,
    output logic [31:0]                 read_addr,
    input  logic [data_width-1:0]       readdata,
    input  logic                        readdatavalid,
    input  logic                        waitrequest,
    output logic [packetizer_width-1:0] packet_out,
    output logic                        packet_out_valid,
    input  logic                        packet_out_ready
);

    send_state_e                 r_state;
    logic [IDX_W-1:0]            r_len;
    logic [IDX_W-1:0]            r_idx;
    logic [31:0]                 r_addr;
    logic [7:0]                  r_dest;
    logic [15:0]                 r_match;
    logic [31:0]                 r_timer;
    logic [31:0]                 r_result;
    logic                        r_done;
    logic                        r_read;
    logic [31:0]                 r_read_addr;
    logic [packetizer_width-1:0] r_packet;
    logic                        r_valid;

    logic [PKT_W-1:0]            w_packet;
    logic [IDX_W-1:0]            w_idx_next;
    logic                        w_timeout;
    logic                        w_last;
    logic                        w_unused;

    assign w_idx_next = r_idx + IDX_W'(1);
    assign w_timeout  = (r_timer >= TIMEOUT);
    assign w_last     = (r_idx == r_len - IDX_W'(1));
    assign w_unused   = ^data_in_a[31:24];

    acc_send_pkt_build u_pkt_build (
        .i_dest     (r_dest),
        .i_rank     (MY_RANK),
        .i_match    (r_match),
        .i_data     (DATA_W'(readdata)),
        .i_idx      (r_idx),
        .o_packet_c (w_packet)
    );

    // Timer counts cycles spent waiting in one state; any state advance clears it.
    always_ff @(posedge nios_clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_dest      <= '0;
            r_match     <= '0;
            r_timer     <= '0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_read      <= 1'b0;
            r_read_addr <= '0;
            r_packet    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (in_opcode)
                            OP_SETLEN: begin
                                r_len    <= data_in_b[IDX_W-1:0];
                                r_result <= {21'b0, data_in_b[IDX_W-1:0]};
                                r_done   <= 1'b1;
                            end
                            OP_SEND: begin
                                r_addr  <= data_in_b;
                                r_dest  <= data_in_a[23:16];
                                r_match <= data_in_a[15:0];
                                r_idx   <= '0;
                                r_timer <= '0;
                                if (r_len == '0) begin
                                    r_result <= 32'h0;
                                    r_state  <= ST_FIN;
                                end else begin
                                    r_read      <= 1'b1;
                                    r_read_addr <= data_in_b;
                                    r_state     <= ST_RD_REQ;
                                end
                            end
                            default: begin
                                r_result <= RES_ILLEGAL;
                                r_done   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_RD_REQ: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_timer <= '0;
                        r_state <= ST_RD_WAIT;
                    end else if (w_timeout) begin
                        r_read   <= 1'b0;
                        r_result <= RES_TIMEOUT;
                        r_state  <= ST_FIN;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_RD_WAIT: begin
                    if (readdatavalid) begin
                        r_packet <= packetizer_width'(w_packet);
                        r_valid  <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= ST_SEND;
                    end else if (w_timeout) begin
                        r_result <= RES_TIMEOUT;
                        r_state  <= ST_FIN;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_SEND: begin
                    if (packet_out_ready) begin
                        r_valid <= 1'b0;
                        r_idx   <= w_idx_next;
                        r_timer <= '0;
                        if (w_last) begin
                            r_result <= {21'b0, r_len};
                            r_state  <= ST_FIN;
                        end else begin
                            r_read      <= 1'b1;
                            r_read_addr <= r_addr + {19'b0, w_idx_next, 2'b00};
                            r_state     <= ST_RD_REQ;
                        end
                    end else if (w_timeout) begin
                        r_valid  <= 1'b0;
                        r_result <= RES_TIMEOUT;
                        r_state  <= ST_FIN;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result           = r_result;
    assign done             = r_done;
    assign read             = r_read;
    assign read_addr        = r_read_addr;
    assign packet_out       = r_packet;
    assign packet_out_valid = r_valid;

endmodule

// File: tb/tb_acc_send.sv
// Randomized scoreboard bench for acc_send: memory/router responders, a
// reference model of reads, packets and completion codes, and a monitor.
module tb_acc_send;

    localparam int unsigned TMO  = 50;
    localparam logic [7:0]  RANK = 8'h5A;
    localparam logic [2:0]  C_SETLEN = 3'b001;
    localparam logic [2:0]  C_SEND   = 3'b010;

    logic         nios_clk = 1'b0;
    logic         reset;
    logic [31:0]  data_in_a, data_in_b;
    logic [2:0]   in_opcode;
    logic         start;
    logic [31:0]  result;
    logic         done;
    logic         read;
    logic [31:0]  read_addr;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic         waitrequest;
    logic [127:0] packet_out;
    logic         packet_out_valid;
    logic         packet_out_ready;

    always #5 nios_clk = ~nios_clk;

    acc_send #(
        .packetizer_width(128),
        .data_width      (32),
        .MY_RANK         (RANK),
        .TIMEOUT         (TMO)
    ) dut (
        .nios_clk        (nios_clk),
        .reset           (reset),
        .data_in_a       (data_in_a),
        .data_in_b       (data_in_b),
        .in_opcode       (in_opcode),
        .start           (start),
        .result          (result),
        .done            (done),
        .read            (read),
        .read_addr       (read_addr),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .waitrequest     (waitrequest),
        .packet_out      (packet_out),
        .packet_out_valid(packet_out_valid),
        .packet_out_ready(packet_out_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0]  q_rd[$];
    logic [31:0]  q_res[$];
    logic [127:0] q_pkt[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [127:0] act);
        n_checks++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [127:0] exp_packet(input logic [7:0] dest, input logic [15:0] match,
                                                input logic [31:0] data, input logic [10:0] idx);
        return {5'b10000, 3'b000, dest, RANK, match, data, 45'd0, idx};
    endfunction

    // Memory and router responders, steered by the mode variables below.
    int   wr_mode = 0;
    int   rdv_max = 0;
    int   rdy_mode = 1;
    int   stall_idx = -1;
    int   stall_left = 0;
    bit   junk_en = 0;
    int   wr_cnt = 0;
    bit   pend = 0;
    int   pend_cnt = 0;
    logic [31:0] pend_data = '0;

    initial begin : responder
        waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0; packet_out_ready = 1'b1;
        forever begin
            @(negedge nios_clk);
            readdatavalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    readdatavalid = 1'b1; readdata = pend_data; pend = 0;
                end else pend_cnt--;
            end else if (junk_en && $urandom_range(3) == 0) begin
                readdatavalid = 1'b1; readdata = $urandom;
            end
            if (read) begin
                if (wr_mode < 0) waitrequest = ($urandom_range(1) == 1);
                else if (wr_cnt < wr_mode) begin waitrequest = 1'b1; wr_cnt++; end
                else waitrequest = 1'b0;
            end else begin
                waitrequest = (wr_mode != 0) ? ($urandom_range(1) == 1) : 1'b0;
                wr_cnt = 0;
            end
            if (rdy_mode == 0) packet_out_ready = 1'b0;
            else if (packet_out_valid && stall_left > 0 && packet_out[10:0] == 11'(stall_idx)) begin
                packet_out_ready = 1'b0; stall_left--;
            end else if (rdy_mode == 2) packet_out_ready = ($urandom_range(1) == 1);
            else packet_out_ready = 1'b1;
            #1;
            if (reset) pend = 0;
            else if (read && !waitrequest) begin
                pend = 1; pend_cnt = int'($urandom_range(rdv_max)); pend_data = mem_word(read_addr);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a transfer.
    int           done_cnt = 0;
    bit           tmo_exp = 0;
    bit           prev_hold = 0;
    logic [127:0] prev_pkt = '0;

    initial begin : monitor
        forever begin
            @(negedge nios_clk);
            #1;
            if (reset) prev_hold = 0;
            else begin
                if (prev_hold && (packet_out_valid || !tmo_exp)) begin
                    chk("hold_valid", 128'(packet_out_valid), 128'(1));
                    chk("hold_packet", packet_out, prev_pkt);
                end
                if (packet_out_valid) chk("no_read_while_pending", 128'(read), 128'(0));
                if (read && !waitrequest) begin
                    if (q_rd.size() == 0) fail_now("unexpected_read", 128'(read_addr));
                    else chk("read_addr", 128'(read_addr), 128'(q_rd.pop_front()));
                end
                if (packet_out_valid && packet_out_ready) begin
                    if (q_pkt.size() == 0) fail_now("unexpected_packet", packet_out);
                    else chk("packet", packet_out, q_pkt.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    if (q_res.size() == 0) fail_now("unexpected_done", 128'(result));
                    else chk("result", 128'(result), 128'(q_res.pop_front()));
                end
                prev_hold = packet_out_valid && !packet_out_ready;
                prev_pkt  = packet_out;
            end
        end
    end

    task automatic cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input bit quick, input int budget, input int mid);
        int base;
        base = done_cnt;
        q_res.push_back(exp_res);
        @(negedge nios_clk);
        start = 1'b1; in_opcode = op; data_in_a = a; data_in_b = b;
        @(negedge nios_clk);
        start = 1'b0;
        if (quick) chk("done_next_cycle", 128'(done), 128'(1));
        for (int i = 0; i < budget; i++) begin
            @(posedge nios_clk);
            if (done_cnt != base) break;
            @(negedge nios_clk);
            start = (mid > 0 && i == mid);
            if (start) begin in_opcode = C_SETLEN; data_in_b = 32'd1; end
        end
        @(negedge nios_clk);
        start = 1'b0;
        if (done_cnt == base) fail_now("done_timeout", 128'(budget));
    endtask

    task automatic push_msg(input int len, input logic [31:0] addr, input logic [7:0] dest,
                            input logic [15:0] match);
        for (int i = 0; i < len; i++) begin
            q_rd.push_back(addr + 32'(i * 4));
            q_pkt.push_back(exp_packet(dest, match, mem_word(addr + 32'(i * 4)), 11'(i)));
        end
    endtask

    task automatic send_msg(input int len, input logic [31:0] addr, input logic [7:0] dest,
                            input logic [15:0] match, input int mid);
        push_msg(len, addr, dest, match);
        cmd(C_SEND, {8'hA5, dest, match}, addr, 32'(len), 1'b0, 200 + len * 80, mid);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_result"}, 128'(result), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_read"}, 128'(read), 128'(0));
        chk({tag, "_read_addr"}, 128'(read_addr), 128'(0));
        chk({tag, "_packet"}, packet_out, 128'(0));
        chk({tag, "_valid"}, 128'(packet_out_valid), 128'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int len;
        logic [31:0] addr;
        start = 1'b0; in_opcode = '0; data_in_a = '0; data_in_b = '0;
        reset = 1'b1;
        repeat (3) @(negedge nios_clk);
        chk_outputs_zero("reset");
        reset = 1'b0;

        cmd(C_SETLEN, 32'h0, 32'd5, 32'h5, 1'b1, 20, 0);
        cmd(3'b111, 32'h0, 32'h0, 32'hbadc0de0, 1'b1, 20, 0);
        cmd(3'b000, 32'h0, 32'h0, 32'hbadc0de0, 1'b1, 20, 0);

        // Basic three-word message, zero-wait memory, ready high.
        cmd(C_SETLEN, 32'h0, 32'd3, 32'h3, 1'b1, 20, 0);
        send_msg(3, 32'h1000, 8'h02, 16'h0107, 0);

        // Router stalls packet 1 for 5 cycles; a start pulse mid-transfer is ignored.
        stall_idx = 1; stall_left = 5;
        send_msg(3, 32'h2000, 8'h11, 16'h0107, 5);
        chk("stall_applied", 128'(stall_left), 128'(0));
        stall_idx = -1;

        // Four-cycle waitrequest plus random read latency.
        wr_mode = 4; rdv_max = 3;
        cmd(C_SETLEN, 32'h0, 32'd4, 32'h4, 1'b1, 20, 0);
        send_msg(4, 32'h3000, 8'h33, 16'hBEEF, 0);
        wr_mode = 0; rdv_max = 0;

        // Zero-length message: no read, no packet.
        cmd(C_SETLEN, 32'h0, 32'd0, 32'h0, 1'b1, 20, 0);
        send_msg(0, 32'h4000, 8'h44, 16'h0001, 0);

        // Randomized traffic, including an address that wraps past 2^32.
        wr_mode = -1; rdv_max = 3; rdy_mode = 2; junk_en = 1;
        for (int k = 0; k < 8; k++) begin
            len  = (k == 0) ? 4 : int'($urandom_range(10, 1));
            addr = (k == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cmd(C_SETLEN, 32'h0, 32'(len), 32'(len), 1'b1, 20, 0);
            send_msg(len, addr, 8'($urandom), 16'($urandom), 0);
        end
        wr_mode = 0; rdv_max = 0; rdy_mode = 1; junk_en = 0;

        // Router never accepts: timeout code, valid and read dropped.
        cmd(C_SETLEN, 32'h0, 32'd2, 32'h2, 1'b1, 20, 0);
        rdy_mode = 0; tmo_exp = 1;
        q_rd.push_back(32'h6000);
        cmd(C_SEND, 32'h0012_0304, 32'h6000, 32'hdeaddead, 1'b0, 400, 0);
        chk("tmo_valid_dropped", 128'(packet_out_valid), 128'(0));
        chk("tmo_read_dropped", 128'(read), 128'(0));
        rdy_mode = 1; tmo_exp = 0;

        // Reset in the middle of a transfer.
        cmd(C_SETLEN, 32'h0, 32'd8, 32'h8, 1'b1, 20, 0);
        push_msg(8, 32'h5000, 8'h55, 16'h0505);
        @(negedge nios_clk);
        start = 1'b1; in_opcode = C_SEND; data_in_a = 32'h0055_0505; data_in_b = 32'h5000;
        @(negedge nios_clk);
        start = 1'b0;
        repeat (7) @(negedge nios_clk);
        reset = 1'b1;
        @(negedge nios_clk);
        chk_outputs_zero("midreset");
        reset = 1'b0;
        q_rd.delete();
        q_pkt.delete();
        repeat (4) @(negedge nios_clk);
        // Length was cleared by reset, so SEND completes immediately with 0.
        send_msg(0, 32'h7000, 8'h77, 16'h0707, 0);

        repeat (5) @(negedge nios_clk);
        chk("reads_drained", 128'(q_rd.size()), 128'(0));
        chk("packets_drained", 128'(q_pkt.size()), 128'(0));
        chk("results_drained", 128'(q_res.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
